match_controller: RTL and testbench

Sequencing FSM for the T20 match, sitting between the debounced button/LFSR front end and the score/ball display path. It accepts one delivery event per request, decodes the LFSR outcome, and accumulates runs, wickets and legal balls per team. It ends each innings on balls or wickets exhausted, ends the chase early when the target is passed, and drives `inning_over`, `game_over`, `winner` and `tie` for the downstream counters and display.

---
 rtl/match_controller.sv | 160 ++++++++++++++++
 tb/tb_match_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// T20 match sequencer: accepts one delivery per ball_req, scores both
// innings, and raises inning_over / game_over / winner / tie.
//
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   start         : pulse; IDLE->INN1 or BREAK->INN2
//   ball_req      : pulse; one delivery, outcome in lfsr_out
//   lfsr_out[3:0] : outcome code
//   view_sel      : 0 = team 1, 1 = team 2 on the display outputs
//   ball_ack      : pulse, delivery accepted
//   inning_over, game_over, winner, tie : match status
//   ball_count, runs, wickets, overs, ball_in_over : selected team
module match_controller #(
    parameter int MAX_BALLS = 120,
    parameter int MAX_WKTS  = 10,
    parameter int RUN_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ball_req,
    input  logic [3:0]       lfsr_out,
    input  logic             view_sel,
    output logic             ball_ack,
    output logic             inning_over,
    output logic             game_over,
    output logic             winner,
    output logic             tie,
    output logic [7:0]       ball_count,
    output logic [RUN_W-1:0] runs,
    output logic [3:0]       wickets,
    output logic [4:0]       overs,
    output logic [2:0]       ball_in_over
);

    localparam logic [7:0] MB = 8'(MAX_BALLS);
    localparam logic [3:0] MW = 4'(MAX_WKTS);

    typedef enum logic [2:0] {IDLE, INN1, BREAK, INN2, DONE} state_t;

    state_t state, state_nx;

    logic [RUN_W-1:0] t1_runs, t2_runs;
    logic [7:0]       t1_balls, t2_balls;
    logic [3:0]       t1_wkts, t2_wkts;

    logic [2:0]       add;
    logic             legal, wkt;
    logic             team2, accept, exhaust;
    logic             win_set, tie_set;
    logic [RUN_W-1:0] cur_runs, nr;
    logic [RUN_W:0]   sum;
    logic [7:0]       cur_balls, nb;
    logic [3:0]       cur_wkts, nw;

    // Outcome decode, active-team update and next state
    always_comb begin
        add       = 3'd0;
        legal     = 1'b0;
        wkt       = 1'b0;
        state_nx  = state;
        win_set   = 1'b0;
        tie_set   = 1'b0;

        unique case (1'b1)
            lfsr_out <= 4'd4: begin
                add   = lfsr_out[2:0];
                legal = 1'b1;
            end
            lfsr_out == 4'd5 || lfsr_out == 4'd7: add = 3'd1;
            lfsr_out == 4'd6: begin
                add   = 3'd6;
                legal = 1'b1;
            end
            lfsr_out[3] && !lfsr_out[2]: begin
                wkt   = 1'b1;
                legal = 1'b1;
            end
            default: legal = 1'b1;
        endcase

        team2     = (state == INN2);
        accept    = ball_req && (state == INN1 || state == INN2);
        cur_runs  = team2 ? t2_runs  : t1_runs;
        cur_balls = team2 ? t2_balls : t1_balls;
        cur_wkts  = team2 ? t2_wkts  : t1_wkts;

        // Widen by one bit so overflow can be detected and clamped
        sum = {1'b0, cur_runs} + (RUN_W+1)'(add);
        nr  = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
        nb  = cur_balls + {7'd0, legal};
        nw  = cur_wkts + {3'd0, wkt};
        exhaust = (nb == MB) || (nw == MW);

        unique case (state)
            IDLE:  if (start) state_nx = INN1;
            INN1:  if (accept && exhaust) state_nx = BREAK;
            BREAK: if (start) state_nx = INN2;
            INN2: begin
                if (accept) begin
                    // Passing the target wins even on the final ball
                    if (nr > t1_runs) begin
                        state_nx = DONE;
                        win_set  = 1'b1;
                    end else if (exhaust) begin
                        state_nx = DONE;
                        tie_set  = (nr == t1_runs);
                    end
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_runs     <= '0;
            t2_runs     <= '0;
            t1_balls    <= '0;
            t2_balls    <= '0;
            t1_wkts     <= '0;
            t2_wkts     <= '0;
            ball_ack    <= 1'b0;
            inning_over <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            tie         <= 1'b0;
        end else begin
            ball_ack <= accept;
            if (accept) begin
                if (team2) begin
                    t2_runs  <= nr;
                    t2_balls <= nb;
                    t2_wkts  <= nw;
                end else begin
                    t1_runs  <= nr;
                    t1_balls <= nb;
                    t1_wkts  <= nw;
                end
            end
            if (state == INN1 && state_nx == BREAK) inning_over <= 1'b1;
            if (state_nx == DONE) game_over <= 1'b1;
            if (win_set) winner <= 1'b1;
            if (tie_set) tie    <= 1'b1;
        end
    end

    assign ball_count   = view_sel ? t2_balls : t1_balls;
    assign runs         = view_sel ? t2_runs  : t1_runs;
    assign wickets      = view_sel ? t2_wkts  : t1_wkts;
    assign overs        = 5'(ball_count / 8'd6);
    assign ball_in_over = 3'(ball_count % 8'd6);

endmodule

// File: tb/tb_match_controller.sv
// Directed and random bench for match_controller against a
// per-team scoreboard model of the match rules.
module tb_match_controller;

    localparam int RUN_W = 8;
    localparam int RMAX  = (1 << RUN_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ball_req = 1'b0;
    logic [3:0]       lfsr_out = 4'd0;
    logic             view_sel = 1'b0;
    logic             ball_ack, inning_over, game_over, winner, tie;
    logic [7:0]       ball_count;
    logic [RUN_W-1:0] runs;
    logic [3:0]       wickets;
    logic [4:0]       overs;
    logic [2:0]       ball_in_over;

    match_controller #(.MAX_BALLS(120), .MAX_WKTS(10), .RUN_W(RUN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ball_req(ball_req),
        .lfsr_out(lfsr_out), .view_sel(view_sel), .ball_ack(ball_ack),
        .inning_over(inning_over), .game_over(game_over),
        .winner(winner), .tie(tie), .ball_count(ball_count),
        .runs(runs), .wickets(wickets), .overs(overs),
        .ball_in_over(ball_in_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // phase: 0 idle, 1 innings 1, 2 break, 3 innings 2, 4 done
    int phase;
    int m_runs[2], m_balls[2], m_wk[2];
    bit m_io, m_go, m_win, m_tie;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        for (int t = 0; t < 2; t++) begin
            m_runs[t] = 0; m_balls[t] = 0; m_wk[t] = 0;
        end
        m_io = 0; m_go = 0; m_win = 0; m_tie = 0;
    endtask

    task automatic model_ball(input int code, output bit acc);
        int t, r, lg, wk;
        acc = 0;
        if (phase == 1 || phase == 3) begin
            acc = 1;
            t = (phase == 3) ? 1 : 0;
            r = 0; lg = 1; wk = 0;
            if (code >= 1 && code <= 4) r = code;
            else if (code == 6) r = 6;
            else if (code == 5 || code == 7) begin r = 1; lg = 0; end
            else if (code >= 8 && code <= 11) wk = 1;
            m_runs[t] = (m_runs[t] + r > RMAX) ? RMAX : m_runs[t] + r;
            m_balls[t] += lg;
            m_wk[t] += wk;
            if (phase == 1) begin
                if (m_balls[0] == 120 || m_wk[0] == 10) begin
                    phase = 2; m_io = 1;
                end
            end else if (m_runs[1] > m_runs[0]) begin
                phase = 4; m_go = 1; m_win = 1;
            end else if (m_balls[1] == 120 || m_wk[1] == 10) begin
                phase = 4; m_go = 1;
                m_tie = (m_runs[1] == m_runs[0]);
            end
        end
    endtask

    task automatic check_all();
        for (int v = 0; v < 2; v++) begin
            view_sel = v[0];
            #1;
            chk($sformatf("runs_v%0d", v), 32'(runs), m_runs[v]);
            chk($sformatf("balls_v%0d", v), 32'(ball_count), m_balls[v]);
            chk($sformatf("wkts_v%0d", v), 32'(wickets), m_wk[v]);
            chk($sformatf("overs_v%0d", v), 32'(overs), m_balls[v] / 6);
            chk($sformatf("bio_v%0d", v), 32'(ball_in_over), m_balls[v] % 6);
        end
        chk("inning_over", 32'(inning_over), 32'(m_io));
        chk("game_over", 32'(game_over), 32'(m_go));
        chk("winner", 32'(winner), 32'(m_win));
        chk("tie", 32'(tie), 32'(m_tie));
    endtask

    task automatic ball(input int code);
        bit acc;
        @(negedge clk);
        ball_req = 1'b1;
        lfsr_out = 4'(code);
        @(posedge clk);
        #1;
        ball_req = 1'b0;
        lfsr_out = 4'($urandom);
        model_ball(code, acc);
        chk("ball_ack", 32'(ball_ack), 32'(acc));
        check_all();
    endtask

    // start pulse, optionally with a simultaneous ball_req
    task automatic do_start(input bit with_ball, input int code);
        bit acc;
        acc = 0;
        @(negedge clk);
        start = 1'b1;
        ball_req = with_ball;
        lfsr_out = 4'(code);
        @(posedge clk);
        #1;
        start = 1'b0;
        ball_req = 1'b0;
        if (phase == 0) phase = 1;
        else if (phase == 2) phase = 3;
        else if (with_ball) model_ball(code, acc);
        chk("start_ack", 32'(ball_ack), 32'(acc));
        check_all();
    endtask

    // Reset asserted between edges; outputs must clear with no clock
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ack", 32'(ball_ack), 0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int dot_code();
        int d;
        d = $urandom_range(0, 4);
        return (d == 0) ? 0 : 11 + d;
    endfunction

    task automatic wickets10();
        for (int i = 0; i < 10; i++) ball($urandom_range(8, 11));
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // Idle: ball ignored
        ball(3);

        // Innings 1 ends on balls
        do_start(1'b1, 2);
        for (int i = 0; i < 120; i++) ball(1);
        view_sel = 1'b0;
        #1;
        chk("b_runs", 32'(runs), 120);
        chk("b_overs", 32'(overs), 20);
        chk("b_bio", 32'(ball_in_over), 0);
        chk("b_io", 32'(inning_over), 1);
        ball(1);
        do_start(1'b1, 4);
        for (int i = 0; i < 400 && phase == 3; i++) ball($urandom_range(0, 15));
        chk("inn2_bound", 32'(game_over), 1);
        ball(2);
        do_start(1'b0, 0);

        // Extras and wickets
        do_reset();
        do_start(1'b0, 0);
        ball(5); ball(7); ball(8);
        view_sel = 1'b0;
        #1;
        chk("x_runs", 32'(runs), 2);
        chk("x_balls", 32'(ball_count), 1);
        chk("x_wkts", 32'(wickets), 1);
        for (int i = 0; i < 9; i++) ball(8);
        view_sel = 1'b0;
        #1;
        chk("x_io", 32'(inning_over), 1);
        chk("x_balls10", 32'(ball_count), 10);

        // Chase won by a wide
        do_reset();
        do_start(1'b0, 0);
        ball(6);
        wickets10();
        do_start(1'b0, 0);
        ball(6);
        ball(5);
        view_sel = 1'b1;
        #1;
        chk("c_go", 32'(game_over), 1);
        chk("c_win", 32'(winner), 1);
        chk("c_tie", 32'(tie), 0);
        chk("c_balls", 32'(ball_count), 1);

        // Tie on exhaustion, then defended total
        for (int k = 0; k < 2; k++) begin
            do_reset();
            do_start(1'b0, 0);
            ball(4); ball(6);
            wickets10();
            do_start(1'b0, 0);
            ball(k == 0 ? 4 : 3);
            ball(6);
            for (int i = 0; i < 118; i++) ball(dot_code());
            chk($sformatf("t_tie%0d", k), 32'(tie), (k == 0) ? 1 : 0);
            chk($sformatf("t_win%0d", k), 32'(winner), 0);
        end

        // Saturation: all sixes both innings
        do_reset();
        do_start(1'b0, 0);
        for (int i = 0; i < 120; i++) ball(6);
        view_sel = 1'b0;
        #1;
        chk("s_sat", 32'(runs), RMAX);
        do_start(1'b0, 0);
        for (int i = 0; i < 120; i++) ball(6);

        // Random games, with a mid-innings-2 reset
        for (int g = 0; g < 3; g++) begin
            do_reset();
            do_start(1'b0, 0);
            for (int i = 0; i < 400 && phase == 1; i++) begin
                if ($urandom_range(0, 7) == 0) do_start(1'b1, $urandom_range(0, 15));
                else ball($urandom_range(0, 15));
            end
            chk("r_io", 32'(inning_over), 1);
            do_start(1'b0, 0);
            if (g == 2) begin
                for (int i = 0; i < 5 && phase == 3; i++) ball($urandom_range(0, 15));
                do_reset();
                do_start(1'b0, 0);
                ball(4);
            end else begin
                for (int i = 0; i < 400 && phase == 3; i++) ball($urandom_range(0, 15));
                chk("r_go", 32'(game_over), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
